// File: rtl/aq_axis_reduce_pkg.sv
// aq_axis_reduce_pkg: state encoding and default geometry/pixel widths
// shared by the DDA image reducer (averaging via AQ_AXIS_REDUCE_AVG_EN).
package aq_axis_reduce_pkg;

    localparam int CH_NUM_DEF = 4;
    localparam int CH_W_DEF   = 8;
    localparam int XY_W_DEF   = 12;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/aq_axis_reduce_dda.sv
// aq_axis_reduce_dda: one decimation axis -- position counter plus
// error accumulator; keep/last describe the element about to be stepped.
module aq_axis_reduce_dda
    import aq_axis_reduce_pkg::*;
#(
    parameter int XY_W = XY_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            step,
    input  logic            clear,
    input  logic [XY_W-1:0] org,
    input  logic [XY_W-1:0] cnv,
    output logic            keep,
    output logic            last
);

    localparam logic [XY_W-1:0] ONE = XY_W'(1);

    logic [XY_W-1:0] r_cnt;
    logic [XY_W:0]   r_acc;
    logic [XY_W:0]   w_sum;
    logic [XY_W:0]   w_nxt;

    assign w_sum = r_acc + {1'b0, cnv};
    assign keep  = (w_sum >= {1'b0, org});
    assign last  = (r_cnt == org - ONE);
    assign w_nxt = keep ? (w_sum - {1'b0, org}) : w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (clear) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (step) begin
            if (last) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + ONE;
                r_acc <= w_nxt;
            end
        end
    end

endmodule

// File: rtl/aq_axis_reduce_px.sv
// aq_axis_reduce_px: AXI-Stream raster reducer with per-axis DDA decimation.
// Define AQ_AXIS_REDUCE_AVG_EN to average each kept pixel with its predecessor.
module aq_axis_reduce_px
    import aq_axis_reduce_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF,
    parameter int CH_W   = CH_W_DEF,
    parameter int XY_W   = XY_W_DEF
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [XY_W-1:0]        ORG_X,
    input  logic [XY_W-1:0]        ORG_Y,
    input  logic [XY_W-1:0]        CNV_X,
    input  logic [XY_W-1:0]        CNV_Y,
    input  logic                   FSYNC_IN,
    output logic                   FSYNC_OUT,
    input  logic [CH_NUM*CH_W-1:0] S_AXIS_TDATA,
    input  logic                   S_AXIS_TVALID,
    input  logic                   S_AXIS_TLAST,
    output logic                   S_AXIS_TREADY,
    output logic [CH_NUM*CH_W-1:0] M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY,
    output logic                   BUSY,
    output logic                   CFG_ERR,
    output logic                   LINE_ERR
);

    localparam int DW = CH_NUM * CH_W;

    logic            r_state;
    logic [XY_W-1:0] r_org_x;
    logic [XY_W-1:0] r_org_y;
    logic [XY_W-1:0] r_cnv_x;
    logic [XY_W-1:0] r_cnv_y;
    logic            r_fsync_out;
    logic            r_cfg_err;
    logic            r_line_err;
    logic            r_m_valid;
    logic            r_m_last;
    logic [DW-1:0]   r_m_data;

    logic            w_geo_ok;
    logic            w_s_ready;
    logic            w_acc;
    logic            w_keep;
    logic            w_x_keep;
    logic            w_x_last;
    logic            w_y_keep;
    logic            w_y_last;
    logic            w_frame_end;
    logic [DW-1:0]   w_pix;

    assign w_geo_ok = (CNV_X != '0) && (CNV_X <= ORG_X) &&
                      (CNV_Y != '0) && (CNV_Y <= ORG_Y);

    assign w_s_ready   = (r_state == ST_IDLE) || !r_m_valid || M_AXIS_TREADY;
    // A beat arriving with FSYNC_IN belongs to neither frame.
    assign w_acc       = S_AXIS_TVALID && w_s_ready &&
                         (r_state == ST_RUN) && !FSYNC_IN;
    assign w_keep      = w_acc && w_x_keep && w_y_keep;
    assign w_frame_end = w_acc && w_x_last && w_y_last;

    aq_axis_reduce_dda #(.XY_W(XY_W)) u_dda_x (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .step  (w_acc),
        .clear (FSYNC_IN),
        .org   (r_org_x),
        .cnv   (r_cnv_x),
        .keep  (w_x_keep),
        .last  (w_x_last)
    );

    aq_axis_reduce_dda #(.XY_W(XY_W)) u_dda_y (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .step  (w_acc && w_x_last),
        .clear (FSYNC_IN),
        .org   (r_org_y),
        .cnv   (r_cnv_y),
        .keep  (w_y_keep),
        .last  (w_y_last)
    );

`ifdef AQ_AXIS_REDUCE_AVG_EN
    logic [DW-1:0] r_prev;
    logic          r_first;
    logic [DW-1:0] w_prev;

    // The first pixel of a line has no predecessor and pairs with itself.
    assign w_prev = r_first ? S_AXIS_TDATA : r_prev;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_prev  <= '0;
            r_first <= 1'b1;
        end else if (FSYNC_IN) begin
            r_first <= 1'b1;
        end else if (w_acc) begin
            r_prev  <= S_AXIS_TDATA;
            r_first <= w_x_last;
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_avg
        logic [CH_W:0] w_sum;
        assign w_sum = {1'b0, S_AXIS_TDATA[c*CH_W +: CH_W]} +
                       {1'b0, w_prev[c*CH_W +: CH_W]} +
                       (CH_W+1)'(1);
        assign w_pix[c*CH_W +: CH_W] = CH_W'(w_sum >> 1);
    end
`else
    assign w_pix = S_AXIS_TDATA;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= ST_IDLE;
            r_org_x     <= '0;
            r_org_y     <= '0;
            r_cnv_x     <= '0;
            r_cnv_y     <= '0;
            r_fsync_out <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_line_err  <= 1'b0;
        end else begin
            r_fsync_out <= 1'b0;
            if (FSYNC_IN) begin
                r_org_x     <= ORG_X;
                r_org_y     <= ORG_Y;
                r_cnv_x     <= CNV_X;
                r_cnv_y     <= CNV_Y;
                r_line_err  <= 1'b0;
                r_cfg_err   <= !w_geo_ok;
                r_fsync_out <= w_geo_ok;
                r_state     <= w_geo_ok ? ST_RUN : ST_IDLE;
            end else begin
                if (w_acc && (S_AXIS_TLAST != w_x_last))
                    r_line_err <= 1'b1;
                if (w_frame_end)
                    r_state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else if (FSYNC_IN) begin
            r_m_valid <= 1'b0;
        end else if (w_keep) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_x_last;
            r_m_data  <= w_pix;
        end else if (M_AXIS_TREADY) begin
            r_m_valid <= 1'b0;
        end
    end

    assign S_AXIS_TREADY = w_s_ready;
    assign M_AXIS_TDATA  = r_m_data;
    assign M_AXIS_TVALID = r_m_valid;
    assign M_AXIS_TLAST  = r_m_last;
    assign FSYNC_OUT     = r_fsync_out;
    assign BUSY          = r_state;
    assign CFG_ERR       = r_cfg_err;
    assign LINE_ERR      = r_line_err;

endmodule

// File: tb/tb_aq_axis_reduce_px.sv
// tb_aq_axis_reduce_px: directed frames with a queue-based scoreboard
// and an independent output monitor.
module tb_aq_axis_reduce_px;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [11:0] ORG_X, ORG_Y, CNV_X, CNV_Y;
    logic        FSYNC_IN;
    logic        FSYNC_OUT;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic        BUSY;
    logic        CFG_ERR;
    logic        LINE_ERR;

    aq_axis_reduce_px dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .ORG_X         (ORG_X),
        .ORG_Y         (ORG_Y),
        .CNV_X         (CNV_X),
        .CNV_Y         (CNV_Y),
        .FSYNC_IN      (FSYNC_IN),
        .FSYNC_OUT     (FSYNC_OUT),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .BUSY          (BUSY),
        .CFG_ERR       (CFG_ERR),
        .LINE_ERR      (LINE_ERR)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    int n_out = 0;
    int n_last = 0;
    int n_fsync = 0;
    int n_exp = 0;
    bit rnd_rdy = 1'b0;
    logic [32:0] q[$];
    logic [31:0] bars[8] = '{32'hFFFFFFFF, 32'hFFFFFF00, 32'hFF00FFFF,
                             32'hFF00FF00, 32'hFFFF00FF, 32'hFFFF0000,
                             32'hFF0000FF, 32'hFF000000};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit keep(input int i, input int o, input int c);
        return (((i + 1) * c) / o) > ((i * c) / o);
    endfunction

    function automatic logic [31:0] pix(input int mode, input int x,
                                        input int y);
        logic [11:0] xx;
        logic [11:0] yy;
        xx = x[11:0];
        yy = y[11:0];
        case (mode)
            0:       return bars[(x / 8) % 8];
            1:       return {8'hA5, yy, xx};
            default: return x[0] ? 32'hFF0000FF : 32'hFF000000;
        endcase
    endfunction

    function automatic logic [31:0] expd(input int mode, input int x,
                                         input int y);
`ifdef AQ_AXIS_REDUCE_AVG_EN
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [8:0]  s;
        if (mode == 2)
            return 32'hFF000080;
        a = pix(mode, x, y);
        b = (x == 0) ? a : pix(mode, x - 1, y);
        for (int c = 0; c < 4; c++) begin
            s = {1'b0, a[c*8 +: 8]} + {1'b0, b[c*8 +: 8]} + 9'd1;
            r[c*8 +: 8] = s[8:1];
        end
        return r;
`else
        return pix(mode, x, y);
`endif
    endfunction

    // Monitor: decides M_AXIS_TREADY and scores every output handshake.
    initial begin
        logic        stall;
        logic [32:0] held;
        logic [32:0] e;
        stall = 1'b0;
        held = '0;
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(negedge ACLK);
            if (stall)
                chk("hold", 64'({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}),
                    64'({1'b1, held}));
            if (FSYNC_OUT)
                n_fsync++;
            M_AXIS_TREADY = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            held = {M_AXIS_TLAST, M_AXIS_TDATA};
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                n_out++;
                if (M_AXIS_TLAST)
                    n_last++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none",
                             M_AXIS_TDATA);
                end else begin
                    e = q.pop_front();
                    chk("beat", 64'({M_AXIS_TLAST, M_AXIS_TDATA}), 64'(e));
                end
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        @(negedge ACLK);
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        for (int t = 0; t < 1000 && !ok; t++) begin
            #1 ok = S_AXIS_TREADY;
            @(posedge ACLK);
            if (!ok)
                @(negedge ACLK);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic idle();
        @(negedge ACLK);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic fsync(input int ox, input int oy, input int cx,
                         input int cy);
        @(negedge ACLK);
        S_AXIS_TVALID = 1'b0;
        ORG_X = 12'(ox);
        ORG_Y = 12'(oy);
        CNV_X = 12'(cx);
        CNV_Y = 12'(cy);
        FSYNC_IN = 1'b1;
        @(negedge ACLK);
        FSYNC_IN = 1'b0;
    endtask

    task automatic frame(input int ox, input int oy, input int cx,
                         input int cy, input int mode, input int nbeats,
                         input int errx);
        int   b;
        int   k;
        bit   ky;
        logic lst;
        logic tl;
        b = 0;
        for (int y = 0; y < oy; y++) begin
            ky = keep(y, oy, cy);
            k = 0;
            for (int x = 0; x < ox; x++) begin
                if (b == nbeats) begin
                    idle();
                    return;
                end
                if (ky && keep(x, ox, cx)) begin
                    lst = (k == cx - 1);
                    q.push_back({lst, expd(mode, x, y)});
                    k++;
                    n_exp++;
                end
                tl = (errx >= 0 && y == 0) ? (x == errx) : (x == ox - 1);
                beat(pix(mode, x, y), tl);
                b++;
            end
        end
        idle();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || M_AXIS_TVALID) && t < 2000) begin
            @(negedge ACLK);
            t++;
        end
        chk("drain_left", 64'(q.size()), 64'(0));
        repeat (3) @(negedge ACLK);
    endtask

    task automatic restart();
        n_out = 0;
        n_last = 0;
        n_exp = 0;
    endtask

    initial begin
        ORG_X = '0;
        ORG_Y = '0;
        CNV_X = '0;
        CNV_Y = '0;
        FSYNC_IN = 1'b0;
        S_AXIS_TDATA = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_mvalid", 64'(M_AXIS_TVALID), 64'(0));
        chk("rst_mlast", 64'(M_AXIS_TLAST), 64'(0));
        chk("rst_mdata", 64'(M_AXIS_TDATA), 64'(0));
        chk("rst_errs", 64'({CFG_ERR, LINE_ERR, FSYNC_OUT}), 64'(0));
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("idle_sready", 64'(S_AXIS_TREADY), 64'(1));

        restart();
        fsync(16, 16, 16, 16);
        chk("id_busy", 64'(BUSY), 64'(1));
        frame(16, 16, 16, 16, 1, 1 << 30, -1);
        drain();
        chk("id_count", 64'(n_out), 64'(256));
        chk("id_tlast", 64'(n_last), 64'(16));
        chk("id_busy_end", 64'(BUSY), 64'(0));
        chk("id_errs", 64'({CFG_ERR, LINE_ERR}), 64'(0));
        chk("id_fsync", 64'(n_fsync), 64'(1));

        restart();
        fsync(64, 64, 48, 48);
        frame(64, 64, 48, 48, 0, 1 << 30, -1);
        drain();
        chk("dec_count", 64'(n_out), 64'(2304));
        chk("dec_tlast", 64'(n_last), 64'(48));
        chk("dec_fsync", 64'(n_fsync), 64'(2));

        restart();
        rnd_rdy = 1'b1;
        fsync(64, 64, 32, 32);
        frame(64, 64, 32, 32, 1, 1 << 30, -1);
        drain();
        rnd_rdy = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("bp_count", 64'(n_out), 64'(1024));
        chk("bp_tlast", 64'(n_last), 64'(32));

        restart();
        fsync(64, 64, 0, 48);
        chk("inv0_cfg", 64'(CFG_ERR), 64'(1));
        chk("inv0_busy", 64'(BUSY), 64'(0));
        for (int i = 0; i < 16; i++)
            beat(32'h1234_0000 + 32'(i), 1'b0);
        idle();
        repeat (4) @(negedge ACLK);
        chk("inv0_out", 64'(n_out), 64'(0));
        fsync(64, 64, 65, 48);
        chk("inv65_cfg", 64'(CFG_ERR), 64'(1));
        chk("inv65_busy", 64'(BUSY), 64'(0));
        chk("inv_fsync", 64'(n_fsync), 64'(3));

        restart();
        fsync(64, 64, 48, 48);
        chk("ab_cfg_clr", 64'(CFG_ERR), 64'(0));
        chk("ab_busy", 64'(BUSY), 64'(1));
        frame(64, 64, 48, 48, 1, 1000, -1);
        drain();
        chk("ab_part", 64'(n_out), 64'(n_exp));
        chk("ab_still_busy", 64'(BUSY), 64'(1));

        restart();
        fsync(64, 64, 48, 48);
        chk("le_clr", 64'(LINE_ERR), 64'(0));
        frame(64, 64, 48, 48, 1, 1 << 30, 62);
        drain();
        chk("le_flag", 64'(LINE_ERR), 64'(1));
        chk("le_count", 64'(n_out), 64'(2304));
        chk("le_tlast", 64'(n_last), 64'(48));
        chk("le_busy_end", 64'(BUSY), 64'(0));
        chk("le_fsync", 64'(n_fsync), 64'(5));

`ifdef AQ_AXIS_REDUCE_AVG_EN
        restart();
        fsync(64, 2, 32, 1);
        frame(64, 2, 32, 1, 2, 1 << 30, -1);
        drain();
        chk("avg_count", 64'(n_out), 64'(32));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
